// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Owner encoding tags which requester the next registered read word belongs to.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    // One-hot grant bit positions out of the read arbiter
    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    // Read-priority pointer: names the requester that wins the next read conflict
    localparam logic PTR_IF = 1'b0;
    localparam logic PTR_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IF   = 2'd1,
        D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way read-port arbiter between fetch and load requests.
// MEMARB_RR_EN selects round-robin; otherwise load has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req_if_i,
    input  logic       req_d_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_next_o
);

    always_comb begin
        gnt_o      = 2'b00;
        ptr_next_o = ptr_i;
`ifdef MEMARB_RR_EN
        if (req_if_i && req_d_i) begin
            // Conflict: pointer names the winner, then moves to the loser
            if (ptr_i == PTR_D) begin
                gnt_o[GNT_D] = 1'b1;
                ptr_next_o   = PTR_IF;
            end else begin
                gnt_o[GNT_IF] = 1'b1;
                ptr_next_o    = PTR_D;
            end
        end else begin
            gnt_o[GNT_IF] = req_if_i;
            gnt_o[GNT_D]  = req_d_i;
        end
`else
        gnt_o[GNT_D]  = req_d_i;
        gnt_o[GNT_IF] = req_if_i && !req_d_i;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory's single read and single write port between fetch and LSU.
// Read policy is set by MEMARB_RR_EN (round-robin) in mem_arb_pick; default is load-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e     owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic       st_gnt;
    logic       raw_hazard;
    logic       rd_if_req, rd_d_req;
    logic [1:0] rd_gnt;

    // Stores never contend; a fetch to the address being written waits a cycle
    assign st_gnt     = !rst && d_req && d_we;
    assign raw_hazard = st_gnt && (if_addr == d_addr);
    assign rd_if_req  = !rst && if_req && !raw_hazard;
    assign rd_d_req   = !rst && d_req && !d_we;

    mem_arb_pick u_pick (
        .req_if_i   (rd_if_req),
        .req_d_i    (rd_d_req),
        .ptr_i      (ptr_q),
        .gnt_o      (rd_gnt),
        .ptr_next_o (ptr_d)
    );

    always_comb begin
        if_gnt    = rd_gnt[GNT_IF];
        d_gnt     = st_gnt || rd_gnt[GNT_D];
        mem_wen   = st_gnt;
        mem_waddr = d_addr;
        mem_wdata = d_wdata;
        mem_ren   = rd_gnt[GNT_IF] || rd_gnt[GNT_D];
        mem_raddr = rd_gnt[GNT_D] ? d_addr : if_addr;

        owner_d = IDLE;
        if (rd_gnt[GNT_D]) begin
            owner_d = D;
        end else if (rd_gnt[GNT_IF]) begin
            owner_d = IF;
        end
    end

    // With fixed priority ptr_d equals ptr_q, so this flop is a constant and trims away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= IDLE;
            ptr_q   <= PTR_D;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        if_rvalid = (owner_q == IF);
        d_rvalid  = (owner_q == D);
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small registered-read memory model.
// Expectations for read conflicts follow MEMARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr[7:0]];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        $display("t=%0t drive if_req=%0b if_addr=%h d_req=%0b d_we=%0b d_addr=%h d_wdata=%h",
                 $time, ir, ia, dr, dw, da, dwd);
    endtask

    // Expected conflict winners for three consecutive fetch-vs-load cycles
    logic [2:0] exp_d_win;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h01] = 32'h11111111;
        mem[8'h02] = 32'h22222222;
        mem[8'h08] = 32'h88888888;
`ifdef MEMARB_RR_EN
        exp_d_win = 3'b101;
`else
        exp_d_win = 3'b111;
`endif

        // Reset: requests present but everything forced quiet
        rst = 1'b1;
        drive(1'b1, 16'h0004, 1'b1, 1'b1, 16'h0010, 32'h1);
        #1;
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        rst = 1'b0;

        // Idle
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        chk("idle_mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("idle_mem_ren", {31'b0, mem_ren}, 32'd0);
        chk("idle_gnts", {30'b0, if_gnt, d_gnt}, 32'd0);
        @(posedge clk); #1;
        chk("idle_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);

        // Lone fetch of 0x0004
        @(negedge clk);
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        chk("f4_if_gnt", {31'b0, if_gnt}, 32'd1);
        chk("f4_mem_ren", {31'b0, mem_ren}, 32'd1);
        chk("f4_mem_raddr", {16'b0, mem_raddr}, 32'h0004);
        @(posedge clk); #1;
        chk("f4_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("f4_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("f4_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // Fetch 0x0001 vs load 0x0002 for three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 32'h0);
            #1;
            chk($sformatf("cf%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, exp_d_win[c]});
            chk($sformatf("cf%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, !exp_d_win[c]});
            @(posedge clk); #1;
            chk($sformatf("cf%0d_d_rvalid", c), {31'b0, d_rvalid}, {31'b0, exp_d_win[c]});
            chk($sformatf("cf%0d_if_rvalid", c), {31'b0, if_rvalid}, {31'b0, !exp_d_win[c]});
            chk($sformatf("cf%0d_rdata", c), d_rdata,
                exp_d_win[c] ? 32'h22222222 : 32'h11111111);
        end

        // Store and fetch to the same address: fetch held off one cycle
        @(negedge clk);
        drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 32'h12345678);
        #1;
        chk("haz_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("haz_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("haz_mem_wen", {31'b0, mem_wen}, 32'd1);
        chk("haz_mem_ren", {31'b0, mem_ren}, 32'd0);
        chk("haz_mem_waddr", {16'b0, mem_waddr}, 32'h0010);
        chk("haz_mem_wdata", mem_wdata, 32'h12345678);
        @(posedge clk); #1;
        chk("haz_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        @(negedge clk);
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        chk("haz2_if_gnt", {31'b0, if_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("haz2_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("haz2_if_rdata", if_rdata, 32'h12345678);

        // Store and fetch to different addresses proceed together
        @(negedge clk);
        drive(1'b1, 16'h0008, 1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5);
        #1;
        chk("par_gnts", {30'b0, if_gnt, d_gnt}, 32'd3);
        chk("par_enables", {30'b0, mem_wen, mem_ren}, 32'd3);
        chk("par_mem_raddr", {16'b0, mem_raddr}, 32'h0008);
        @(posedge clk); #1;
        chk("par_if_rdata", if_rdata, 32'h88888888);
        chk("par_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd2);

        // Load back the stored word
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
        #1;
        chk("ld20_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("ld20_mem_raddr", {16'b0, mem_raddr}, 32'h0020);
        @(posedge clk); #1;
        chk("ld20_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("ld20_d_rdata", d_rdata, 32'hA5A5A5A5);

        // Reset lands while a load response is out
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 32'h0);
        #1;
        chk("rl_d_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("rl_d_rvalid_pre", {31'b0, d_rvalid}, 32'd1);
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("rl_d_rvalid_async", {31'b0, d_rvalid}, 32'd0);
        chk("rl_if_gnt_rst", {31'b0, if_gnt}, 32'd0);
        chk("rl_mem_ren_rst", {31'b0, mem_ren}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk); #1;
        chk("rl_post_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);

        // Pointer back at D after reset: load wins the first conflict
        @(negedge clk);
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 32'h0);
        #1;
        chk("pr_gnts", {30'b0, if_gnt, d_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("pr_d_rdata", d_rdata, 32'h22222222);

        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk); #1;
        chk("end_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single read port and single write port of the combined instruction/data memory between the instruction-fetch unit (read-only) and the load/store unit (read or write). Grants are issued combinationally in the request cycle. Read responses are routed back to the winning requester one cycle later, matching the memory's registered read. The block sits between the core front-end/LSU and the memory, and is the only driver of the memory's `wen`/`ren`/address/data inputs.

## Interface
- `ADDR_W`, 16, word address width (matches memory address ports)
- `DATA_W`, 32, data word width

- `clk`  in  1  core clock; memory shares this clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request; held until granted
- `if_addr`  in  ADDR_W  fetch word address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  LSU request; held until granted
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  LSU word address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  LSU request accepted this cycle
- `d_rvalid`  out  1  load data valid (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data
- `mem_wen`, `mem_ren`  out  1  memory write/read enables
- `mem_waddr`, `mem_raddr`  out  ADDR_W  memory addresses
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory registered read data

## Operation
- A transaction is accepted when `req && gnt` on a rising edge. Requesters must hold `req`, address and data stable until granted.
- **Stores:**
  - Use the write port only. `d_gnt = 1` whenever `d_req && d_we`, with no conflict with fetch.
  - Drive `mem_wen=1`, `mem_waddr=d_addr`, `mem_wdata=d_wdata`. No `d_rvalid` is generated.
- **Reads** (fetch, or load with `d_we=0`) compete for the read port. At most one read is granted per cycle. The winner drives `mem_ren=1` and `mem_raddr`.
- **Read/write hazard:**
  - If a store is granted this cycle and a fetch read targets the same address, the fetch is not granted.
  - The fetch retries the next cycle, so it never receives stale data.
- **Response owner register** (`owner`: IDLE / IF / D):
  - Loads the read winner on a granted read. Otherwise it loads IDLE.
  - `owner==IF` drives `if_rvalid=1` and `if_rdata=mem_rdata`. `owner==D` drives `d_rvalid=1` and `d_rdata=mem_rdata`. Otherwise both rvalid outputs are 0.
  - rdata outputs are `mem_rdata`, unmasked.
- **Reset:**
  - `owner=IDLE`, priority pointer = D.
  - All rvalids are 0 immediately, asynchronously. A response in flight is dropped.
  - Grants and mem enables are combinational. They follow the inputs during reset but are forced to 0 while `rst=1`.

## Timing
- Grant latency 0: `gnt` is combinational from `req`, `we`, addresses and pointer.
- Read latency 1: a read granted in cycle N gives `rvalid` in N+1.
- Back-to-back reads from one requester sustain one per cycle.
- A store and a read in the same cycle both proceed, except under the hazard rule above.
- Simultaneous fetch read and load read: the winner comes from the arbitration policy (see Configuration). The loser's `gnt=0`.
- The pointer updates only on cycles where both reads are requested. It points to the loser, so the loser wins next time.

## Configuration
- `MEMARB_RR_EN` defined: round-robin between fetch and load on a read conflict, with a 1-bit pointer as above. Neither requester waits more than one conflicting cycle.
- Undefined: fixed priority, with load always winning. The pointer register is not implemented, and fetch can stall indefinitely under continuous loads.

## Structure
- Package `mem_arb_pkg`:
  - `owner_e` enum (IDLE, IF, D).
  - Default `ADDR_W`/`DATA_W` localparams.
- Sub-module `mem_arb_pick`: 2-way read arbiter.
  - Inputs: two requests and the pointer.
  - Outputs: one-hot grant and next pointer.
  - Contains the `MEMARB_RR_EN` compile switch.

## Test plan
- Memory word 0x0004=0xDEADBEEF. Fetch read 0x0004 alone → `if_gnt=1` same cycle; next cycle `if_rvalid=1`, `if_rdata=0xDEADBEEF`, `d_rvalid=0`.
- Fetch read 0x0001 and load 0x0002 for 3 cycles, `MEMARB_RR_EN` defined → grants D, IF, D; rvalids alternate one cycle later. Undefined → D, D, D, with `if_gnt=0` throughout.
- Store 0x0010←0x12345678 with fetch read 0x0010 in the same cycle → `d_gnt=1`, `if_gnt=0`; fetch granted next cycle, then `if_rdata=0x12345678`.
- Store 0x0020←0xA5A5A5A5 with fetch read 0x0008 in the same cycle → both granted, `mem_wen=mem_ren=1`.
- Load granted, then `rst` asserted mid-cycle before the response edge → `d_rvalid` 0 immediately; after release, `owner=IDLE` with no spurious rvalid.
- No requests → `mem_wen=mem_ren=0`, all gnt/rvalid 0.
